// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    OUT,
    ADV,
    ERR
  } if_state_e;

  localparam int BR_OFF_W = 16;
  localparam int PC_INC   = 4;

endpackage

// File: rtl/if_watchdog.sv
// Request watchdog: a down-counter, reloaded while cleared, that raises expired
// at terminal count. expired is high during the TIMEOUT-th enabled cycle.
module if_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: fetches at pc over req/ack, hands the word to
// decode over valid/ready, then pulses update (+4 or branch). Optional
// alignment fault enabled by IF_ALIGN_CHECK_EN.
//
//   state | meaning
//   IDLE  | waiting for stall low, latches pc into mem_addr
//   REQ   | memory request outstanding, watchdog running
//   OUT   | instruction offered to decode
//   ADV   | one-cycle PC advance (update pulse)
//   ERR   | sticky fault, left only by rst
module instr_fetch
  import if_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   pc,
  output logic                update,
  output logic                branch,
  output logic [BR_OFF_W-1:0] branch_offset,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [INSTR_W-1:0]  mem_rdata,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                br_req,
  input  logic [BR_OFF_W-1:0] br_offset,
  input  logic                stall,
  output logic                fetch_err
);

  if_state_e           state;
  logic                br_pend;
  logic [BR_OFF_W-1:0] pend_off;
  logic                wd_clr;
  logic                wd_en;
  logic                wd_expired;

  assign wd_clr = (state != REQ);
  assign wd_en  = (state == REQ) && !mem_ack;

  if_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      update      <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_err   <= 1'b0;
      br_pend     <= 1'b0;
      pend_off    <= '0;
    end else begin
      update <= 1'b0;

      if ((state != ERR) && br_req) begin
        br_pend  <= 1'b1;
        pend_off <= br_offset;
      end

      case (state)
        IDLE: begin
          if (!stall) begin
`ifdef IF_ALIGN_CHECK_EN
            if (pc[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else
`endif
            begin
              mem_addr <= pc;
              mem_req  <= 1'b1;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            instr       <= mem_rdata;
            instr_pc    <= mem_addr;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
            state       <= OUT;
          end else if (wd_expired) begin
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            state     <= ERR;
          end
        end
        OUT: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            update      <= 1'b1;
            state       <= ADV;
          end
        end
        ADV: begin
          // the branch (pending or same-cycle) is consumed by this advance
          br_pend <= 1'b0;
          state   <= IDLE;
        end
        ERR: begin
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign branch        = (state == ADV) && (br_pend || br_req);
  assign branch_offset = (state == ADV) ? (br_req ? br_offset : pend_off) : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: models the program counter and drives memory
// and decode handshakes step by step with hand-computed expectations.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        update;
  logic        branch;
  logic [15:0] branch_offset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        br_req;
  logic [15:0] br_offset;
  logic        stall;
  logic        fetch_err;

  logic [31:0] pc_model;
  logic        pc_force_en;
  logic [31:0] pc_force;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_upd    = 0;
  int          upd_base;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W (32),
    .INSTR_W(32),
    .TIMEOUT(5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .update       (update),
    .branch       (branch),
    .branch_offset(branch_offset),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .br_req       (br_req),
    .br_offset    (br_offset),
    .stall        (stall),
    .fetch_err    (fetch_err)
  );

  // program counter model
  always @(posedge clk or posedge rst) begin
    if (rst) pc_model <= 32'h0;
    else if (update) pc_model <= branch ? pc_model + {16'h0, branch_offset} : pc_model + 32'd4;
  end

  always @(posedge clk) if (update) n_upd <= n_upd + 1;

  assign pc = pc_force_en ? pc_force : pc_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b0;
    br_req = 1'b0; br_offset = 16'h0; stall = 1'b0;
    pc_force_en = 1'b0; pc_force = 32'h0;
    #1;
    check("rst_update", update, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_err", fetch_err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_br_off", branch_offset, 0);
    step(); step();
    rst = 1'b0;

    // zero-wait fetch at 0x0
    check("t1_idle_req", mem_req, 0);
    step();
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hC0DE_0000;
    step();
    check("t1_valid", instr_valid, 1);
    check("t1_instr", instr, 32'hC0DE_0000);
    check("t1_instr_pc", instr_pc, 32'h0);
    check("t1_req_drop", mem_req, 0);
    mem_ack = 1'b0; instr_ready = 1'b1;
    step();
    check("t1_update", update, 1);
    check("t1_branch", branch, 0);
    instr_ready = 1'b0;
    step();
    check("t1_upd_pulse", update, 0);
    step();

    // ack delayed 3 cycles, ready delayed 2
    for (int i = 0; i < 3; i++) begin
      check("t2_req_hold", mem_req, 1);
      check("t2_addr_hold", mem_addr, 32'h4);
      step();
    end
    check("t2_req_4th", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'hC0DE_0004;
    step();
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    upd_base = n_upd;
    for (int i = 0; i < 2; i++) begin
      check("t2_valid", instr_valid, 1);
      check("t2_instr", instr, 32'hC0DE_0004);
      check("t2_no_upd", update, 0);
      step();
    end
    check("t2_instr_pc", instr_pc, 32'h4);
    instr_ready = 1'b1;
    step();
    check("t2_update", update, 1);
    instr_ready = 1'b0;
    step();
    check("t2_one_update", n_upd - upd_base, 1);

    // branch requested during REQ
    step();
    check("t3_addr", mem_addr, 32'h8);
    br_req = 1'b1; br_offset = 16'h0010;
    step();
    br_req = 1'b0; br_offset = 16'h0;
    check("t3_req_held", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'hC0DE_0008;
    step();
    mem_ack = 1'b0; instr_ready = 1'b1;
    step();
    check("t3_update", update, 1);
    check("t3_branch", branch, 1);
    check("t3_br_off", branch_offset, 16'h0010);
    instr_ready = 1'b0;
    step();
    check("t3_branch_idle", branch, 0);
    check("t3_off_idle", branch_offset, 0);
    step();
    check("t3_target", mem_addr, 32'h18);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; instr_ready = 1'b1;
    step();
    check("t3_upd2", update, 1);
    check("t3_no_branch2", branch, 0);
    instr_ready = 1'b0;

    // pending 0x8 overridden by 0x20 in ADV
    step();
    br_req = 1'b1; br_offset = 16'h0008;
    step();
    br_req = 1'b0; br_offset = 16'h0;
    check("t4_addr", mem_addr, 32'h1C);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t4_pend_branch", branch, 1);
    check("t4_pend_off", branch_offset, 16'h0008);
    br_req = 1'b1; br_offset = 16'h0020;
    #1;
    check("t4_newest_off", branch_offset, 16'h0020);
    step();
    br_req = 1'b0; br_offset = 16'h0;
    step();
    check("t4_target", mem_addr, 32'h3C);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; instr_ready = 1'b1;
    step();
    check("t4_upd", update, 1);
    check("t4_pend_cleared", branch, 0);
    instr_ready = 1'b0;

    // timeout, TIMEOUT=5
    step(); step();
    check("t5_addr", mem_addr, 32'h40);
    upd_base = n_upd;
    for (int i = 0; i < 5; i++) begin
      check("t5_no_err", fetch_err, 0);
      check("t5_req", mem_req, 1);
      step();
    end
    check("t5_err", fetch_err, 1);
    check("t5_req_off", mem_req, 0);
    mem_ack = 1'b1; instr_ready = 1'b1;
    step(); step();
    mem_ack = 1'b0; instr_ready = 1'b0;
    check("t5_err_sticky", fetch_err, 1);
    check("t5_valid_off", instr_valid, 0);
    check("t5_no_update", n_upd - upd_base, 0);
    rst = 1'b1;
    #1;
    check("t5_rst_err", fetch_err, 0);
    step();
    rst = 1'b0; stall = 1'b1;
    step(); step();
    check("t5_stall", mem_req, 0);
    stall = 1'b0;
    step();
    check("t5_recover_req", mem_req, 1);
    check("t5_recover_addr", mem_addr, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    check("t5_recover_instr", instr, 32'h1234_5678);

    // misaligned pc
    rst = 1'b1; pc_force_en = 1'b1; pc_force = 32'h6;
    step();
    rst = 1'b0;
    step();
`ifdef IF_ALIGN_CHECK_EN
    check("t6_no_req", mem_req, 0);
    check("t6_err", fetch_err, 1);
`else
    check("t6_req", mem_req, 1);
    check("t6_addr", mem_addr, 32'h6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer that drives the program counter's control side (`update`, `branch`, `branch_offset`) and consumes its `pc` output. Each instruction is fetched from instruction memory over a req/ack handshake, presented to decode over a valid/ready handshake, and the PC is then advanced by 4 or by a branch offset. It sits between the program counter, instruction memory and the decode stage.

## Interface
- `ADDR_W`, 32, PC / memory address width
- `INSTR_W`, 32, instruction width
- `TIMEOUT`, 255, maximum cycles `mem_req` may wait for `mem_ack` before faulting (≥1)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pc`  in  ADDR_W  current PC from the program counter
- `update`  out  1  one-cycle pulse: PC advances at this edge
- `branch`  out  1  valid with `update`: take branch offset instead of +4
- `branch_offset`  out  16  offset, zero-extended by the PC
- `mem_req`  out  1  instruction memory read request
- `mem_addr`  out  ADDR_W  read address, equals `pc` captured at request start
- `mem_ack`  in  1  read data valid this cycle
- `mem_rdata`  in  INSTR_W  read data
- `instr_valid`  out  1  instruction available to decode
- `instr_ready`  in  1  decode accepts instruction
- `instr`  out  INSTR_W  fetched instruction
- `instr_pc`  out  ADDR_W  address of `instr`
- `br_req`  in  1  one-cycle branch request from execute
- `br_offset`  in  16  offset accompanying `br_req`
- `stall`  in  1  hold off starting a new fetch
- `fetch_err`  out  1  sticky fetch fault

## Operation
- States: IDLE, REQ, OUT, ADV, ERR. Reset → IDLE.
- IDLE: `stall`=1 → stay; else latch `mem_addr`←`pc`, → REQ.
- REQ: `mem_req`=1, `mem_addr` stable. `mem_ack`=1 → capture `instr`←`mem_rdata`, `instr_pc`←`mem_addr`, → OUT. Else wait counter +1; counter reaches `TIMEOUT` → `fetch_err`=1, → ERR.
- OUT: `instr_valid`=1, `instr`/`instr_pc` stable until transfer (`instr_valid`&`instr_ready`) → ADV.
- ADV (exactly one cycle): `update`=1; → IDLE. PC reflects new value in the following cycle, so the next IDLE→REQ uses the updated `pc`.
- Branch capture: `br_req`=1 in any non-ERR state sets `br_pend` and `pend_off`←`br_offset`; a later `br_req` overwrites the offset.
- In ADV: `branch` = `br_pend` | `br_req`; `branch_offset` = `br_req` ? `br_offset` : `pend_off` (newest wins); `br_pend` cleared at that edge. Outside ADV `branch`=0, `branch_offset`=0.
- `stall` affects only IDLE; it never aborts REQ or withdraws `instr_valid`.
- `mem_ack` ignored outside REQ.
- ERR: all handshake outputs 0, `fetch_err`=1; exit only via `rst`.

## Timing
- Reset values: `update`, `branch`, `mem_req`, `instr_valid`, `fetch_err` = 0; `branch_offset`, `mem_addr`, `instr`, `instr_pc` = 0.
- `rst` mid-operation: outstanding request abandoned immediately; `br_pend` and counter cleared.
- Minimum loop, zero-wait memory and decode: IDLE, REQ(ack), OUT(ready), ADV = 4 cycles per instruction.
- `instr_valid` rises the cycle after the ack edge; `update` is high the cycle after the transfer edge.
- Timeout: with `TIMEOUT`=N and no ack, `fetch_err` rises at the edge ending the Nth REQ cycle.
- All outputs registered or decoded from state only; no input-to-output combinational paths except `branch`/`branch_offset` from `br_req`/`br_offset` in ADV.

## Configuration
- `IF_ALIGN_CHECK_EN` defined: in IDLE, if `pc[1:0]`≠0 and `stall`=0, no request is issued; `fetch_err`←1, → ERR.
- Undefined: no alignment check; `pc` low bits passed to `mem_addr` unchanged.

## Structure
- Package `if_pkg`: state enum (IDLE, REQ, OUT, ADV, ERR), `BR_OFF_W`=16, `PC_INC`=4.
- One sub-module, `if_watchdog`: cycle counter with clear/enable inputs and a `TIMEOUT` parameter, raising `expired`.

## Test plan
- Reset, `pc`=0x0, zero-wait memory and decode → `mem_addr`=0x0, `instr` equals memory word, `update`=1 with `branch`=0 four cycles after reset release, then next request at 0x4.
- `mem_ack` delayed 3 cycles, `instr_ready` delayed 2 → `mem_req`/`mem_addr` held 4 cycles, `instr` stable while `instr_valid` is high, exactly one `update` pulse.
- `br_req` with offset 0x0010 during REQ → next `update` has `branch`=1 and `branch_offset`=0x0010; the following `update` has `branch`=0.
- `br_req` offset 0x0008 pending, then `br_req` offset 0x0020 in the ADV cycle → `branch_offset`=0x0020 and pending cleared.
- `TIMEOUT`=5, no ack → `fetch_err`=1 after 5 REQ cycles, `mem_req`=0, no `update`; `rst` recovers to IDLE.
- `IF_ALIGN_CHECK_EN` defined, `pc`=0x6 → no `mem_req`, `fetch_err`=1 the cycle after IDLE.
